// File: rtl/adc_monitor_scan_ctrl_if.sv
// AXI-Stream master/slave bundle carrying captured monitor words tagged with a tile index.
interface adc_monitor_scan_ctrl_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned USER_W = 3
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tready;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/adc_monitor_scan_ctrl.sv
// Steps the ADC monitor mux through a masked tile set, waits for the mux to settle,
// captures a fixed-length burst per tile and streams it out with the tile index in tuser.
module adc_monitor_scan_ctrl #(
    parameter int unsigned NUMBER_OF_LINE = 8,
    parameter int unsigned CAPTURE_LEN    = 16,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [7:0]                    channel_mask,
    input  logic                          continuous,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    adc_monitor_select,
    input  logic [16*NUMBER_OF_LINE-1:0]  mon_data,
    adc_monitor_scan_ctrl_if.master       m_axis,
    output logic [15:0]                   overrun_count
);

    localparam int unsigned DATA_W = 16 * NUMBER_OF_LINE;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]        mask_q;
    logic [7:0]        remain_q;
    logic [SET_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic              end_flag;

    logic              tvalid_q;
    logic [DATA_W-1:0] tdata_q;
    logic [2:0]        tuser_q;
    logic              tlast_q;
    logic              busy_q;
    logic              done_q;
    logic [2:0]        sel_q;
    logic [15:0]       overrun_q;

    logic              room_c;
    logic              handshake_c;
    logic              last_word_c;
    logic              settled_c;
    logic              more_c;
    logic [2:0]        pick_bit_c;
    logic [7:0]        pick_mask_c;

    logic              accept_c;
    logic              zero_start_c;
    logic              pick_c;
    logic              load_c;
    logic              drop_c;
    logic              restart_c;
    logic              finish_c;
    logic              set_end_c;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Output register can take a new word when empty or emptying this cycle.
    assign handshake_c = tvalid_q & m_axis.tready;
    assign room_c      = ~tvalid_q | m_axis.tready;
    assign last_word_c = (word_cnt == CNT_W'(CAPTURE_LEN - 1));
    assign settled_c   = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign more_c      = (remain_q != 8'd0);
    assign pick_bit_c  = lowest_bit(remain_q);
    assign pick_mask_c = 8'd1 << pick_bit_c;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (channel_mask != 8'd0)) state_next = S_SELECT;
            end
            S_SELECT: begin
                state_next = abort ? S_DRAIN : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)          state_next = S_DRAIN;
                else if (settled_c) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort)                    state_next = S_DRAIN;
                else if (room_c && last_word_c) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (room_c) begin
                    if (end_flag || abort)       state_next = S_IDLE;
                    else if (more_c || continuous) state_next = S_SELECT;
                    else                         state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Per-state control strobes feeding the registered datapath.
    always_comb begin
        accept_c     = 1'b0;
        zero_start_c = 1'b0;
        pick_c       = 1'b0;
        load_c       = 1'b0;
        drop_c       = 1'b0;
        restart_c    = 1'b0;
        finish_c     = 1'b0;
        set_end_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (channel_mask != 8'd0) accept_c     = 1'b1;
                    else                      zero_start_c = 1'b1;
                end
            end
            S_SELECT: begin
                if (abort) set_end_c = 1'b1;
                else       pick_c    = 1'b1;
            end
            S_SETTLE: begin
                if (abort) set_end_c = 1'b1;
            end
            S_CAPTURE: begin
                if (abort)       set_end_c = 1'b1;
                else if (room_c) load_c    = 1'b1;
                else             drop_c    = 1'b1;
            end
            S_DRAIN: begin
                if (abort) set_end_c = 1'b1;
                if (room_c) begin
                    if (end_flag || abort) finish_c  = 1'b1;
                    else if (more_c)       finish_c  = 1'b0;
                    else if (continuous)   restart_c = 1'b1;
                    else                   finish_c  = 1'b1;
                end
            end
            default: begin
                finish_c = 1'b0;
            end
        endcase
    end

    // Sweep bookkeeping: latched mask, tiles still to visit, counters and status.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mask_q     <= 8'd0;
            remain_q   <= 8'd0;
            settle_cnt <= '0;
            word_cnt   <= '0;
            end_flag   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sel_q      <= 3'd0;
            overrun_q  <= 16'd0;
        end else begin
            done_q <= finish_c | zero_start_c;
            if (accept_c) begin
                mask_q    <= channel_mask;
                remain_q  <= channel_mask;
                overrun_q <= 16'd0;
                busy_q    <= 1'b1;
                end_flag  <= 1'b0;
            end
            if (finish_c) busy_q <= 1'b0;
            if (set_end_c) end_flag <= 1'b1;
            if (pick_c) begin
                sel_q      <= pick_bit_c;
                remain_q   <= remain_q & ~pick_mask_c;
                settle_cnt <= '0;
                word_cnt   <= '0;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (restart_c) remain_q <= mask_q;
            if (load_c) word_cnt <= word_cnt + CNT_W'(1);
            if (drop_c && (overrun_q != 16'hFFFF)) overrun_q <= overrun_q + 16'd1;
        end
    end

    // Single-entry output register; payload only changes on a load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= 3'd0;
            tlast_q  <= 1'b0;
        end else if (load_c) begin
            tvalid_q <= 1'b1;
            tdata_q  <= mon_data;
            tuser_q  <= sel_q;
            tlast_q  <= last_word_c;
        end else if (handshake_c) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis.tvalid      = tvalid_q;
    assign m_axis.tdata       = tdata_q;
    assign m_axis.tuser       = tuser_q;
    assign m_axis.tlast       = tlast_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign adc_monitor_select = sel_q;
    assign overrun_count      = overrun_q;

endmodule
